// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with at most two requests in flight, a 2-entry response FIFO
// and branch redirect with drop counting. Define FETCH_PERF_CNT_EN to add the StallCnt/RedirCnt counters.
module fetch_unit #(
    parameter int unsigned       SIZE     = 48,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       PC_INC   = 6,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              StallF,
    input  logic              BranchTakenE,
    input  logic [ADDR_W-1:0] PCTargetE,
    output logic              IMemReq,
    output logic [ADDR_W-1:0] IMemAddr,
    input  logic              IMemGnt,
    input  logic              IMemRValid,
    input  logic [SIZE-1:0]   IMemRData,
    output logic [SIZE-1:0]   InstrF,
    output logic [ADDR_W-1:0] PCF,
    output logic              ValidF
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       StallCnt,
    output logic [31:0]       RedirCnt
`endif
);

    localparam int unsigned CNT_W  = 2;
    localparam int unsigned SUM_W  = CNT_W + 1;
    localparam int unsigned PERF_W = 32;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_resp_pc;
    logic [ADDR_W-1:0] r_pc;
    logic [SIZE-1:0]   r_instr;
    logic              r_valid;
    logic [CNT_W-1:0]  r_out;
    logic [CNT_W-1:0]  r_drop;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_out_nxt;
    logic              r_wptr;
    logic              r_rptr;
    logic [SIZE-1:0]   r_fifo_data [2];
    logic [ADDR_W-1:0] r_fifo_pc   [2];
    logic              w_branch;
    logic              w_acc;
    logic              w_keep;
    logic              w_pop;
    logic              w_bypass;
    logic              w_push;
    logic              w_room;

    // Responses are only kept in RUN and never in the cycle a redirect is taken
    assign w_branch  = BranchTakenE && (r_state != S_IDLE);
    assign w_acc     = IMemReq && IMemGnt;
    assign w_keep    = IMemRValid && (r_state == S_RUN) && !w_branch;
    assign w_pop     = !StallF && (r_cnt != '0);
    assign w_bypass  = !StallF && (r_cnt == '0) && w_keep;
    assign w_push    = w_keep && !w_bypass;
    assign w_out_nxt = r_out + CNT_W'(w_acc) - CNT_W'(IMemRValid);
    assign w_room    = (SUM_W'(r_out) + SUM_W'(r_cnt)) < SUM_W'(2);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     w_state_nxt = S_RUN;
            S_RUN:      if (w_branch) w_state_nxt = S_REDIRECT;
            S_REDIRECT: if (!w_branch && w_acc) w_state_nxt = S_RUN;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Fetch only while in-flight plus buffered leaves room; after a redirect wait for all drops
    always_comb begin
        IMemReq = 1'b0;
        case (r_state)
            S_RUN:      IMemReq = w_room;
            S_REDIRECT: IMemReq = w_room && (r_drop == '0);
            default:    IMemReq = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_addr    <= RESET_PC;
            r_resp_pc <= RESET_PC;
            r_out     <= '0;
            r_drop    <= '0;
            r_cnt     <= '0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_instr   <= '0;
            r_pc      <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_out <= w_out_nxt;
            if (w_branch) begin
                r_addr    <= PCTargetE;
                r_resp_pc <= PCTargetE;
                r_drop    <= w_out_nxt;
                r_cnt     <= '0;
                r_wptr    <= 1'b0;
                r_rptr    <= 1'b0;
                r_instr   <= '0;
                r_valid   <= 1'b0;
            end else begin
                if (w_acc) r_addr <= r_addr + ADDR_W'(PC_INC);
                if (w_keep) r_resp_pc <= r_resp_pc + ADDR_W'(PC_INC);
                if ((r_state == S_REDIRECT) && IMemRValid && (r_drop != '0)) begin
                    r_drop <= r_drop - CNT_W'(1);
                end
                if (w_push) r_wptr <= ~r_wptr;
                if (w_pop) r_rptr <= ~r_rptr;
                r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
                if (!StallF) begin
                    if (w_pop) begin
                        r_instr <= r_fifo_data[r_rptr];
                        r_pc    <= r_fifo_pc[r_rptr];
                        r_valid <= 1'b1;
                    end else if (w_bypass) begin
                        r_instr <= IMemRData;
                        r_pc    <= r_resp_pc;
                        r_valid <= 1'b1;
                    end else begin
                        r_instr <= '0;
                        r_valid <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_data[r_wptr] <= IMemRData;
            r_fifo_pc[r_wptr]   <= r_resp_pc;
        end
    end

    assign IMemAddr = r_addr;
    assign InstrF   = r_instr;
    assign PCF      = r_pc;
    assign ValidF   = r_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_redir_cnt;

    // Saturating event counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
            r_redir_cnt <= '0;
        end else begin
            if (StallF && r_valid && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            if (w_branch && (r_redir_cnt != '1)) r_redir_cnt <= r_redir_cnt + PERF_W'(1);
        end
    end

    assign StallCnt = r_stall_cnt;
    assign RedirCnt = r_redir_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit with an in-order memory model of configurable latency
// and a PC scoreboard; optional counter checks follow FETCH_PERF_CNT_EN.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        StallF;
    logic        BranchTakenE;
    logic [31:0] PCTargetE;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemGnt;
    logic        IMemRValid;
    logic [47:0] IMemRData;
    logic [47:0] InstrF;
    logic [31:0] PCF;
    logic        ValidF;

    logic        w2_req;
    logic [31:0] w2_addr;
    logic [47:0] w2_instr;
    logic [31:0] w2_pc;
    logic        w2_valid;
    logic        tie0 = 1'b0;
    logic [47:0] tie_data = '0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] StallCnt, RedirCnt, w2_stall_cnt, w2_redir_cnt;
`endif

    fetch_unit u_dut (
        .CLK(CLK), .RST(RST), .StallF(StallF), .BranchTakenE(BranchTakenE), .PCTargetE(PCTargetE),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemGnt(IMemGnt), .IMemRValid(IMemRValid),
        .IMemRData(IMemRData), .InstrF(InstrF), .PCF(PCF), .ValidF(ValidF)
`ifdef FETCH_PERF_CNT_EN
        , .StallCnt(StallCnt), .RedirCnt(RedirCnt)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .CLK(CLK), .RST(RST), .StallF(StallF), .BranchTakenE(BranchTakenE), .PCTargetE(PCTargetE),
        .IMemReq(w2_req), .IMemAddr(w2_addr), .IMemGnt(IMemGnt), .IMemRValid(tie0),
        .IMemRData(tie_data), .InstrF(w2_instr), .PCF(w2_pc), .ValidF(w2_valid)
`ifdef FETCH_PERF_CNT_EN
        , .StallCnt(w2_stall_cnt), .RedirCnt(w2_redir_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] a;
        int          t;
    } mreq_t;

    typedef struct {
        logic        stall;
        logic        gnt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    mreq_t       mq[$];
    logic [31:0] sb[$];
    int          ncyc = 0;
    int          lat = 1;
    int          nacc = 0;
    int          nrv = 0;
    int          total = 0;
    int          bad = 0;
    logic        gnt_en = 1'b1;

    function automatic logic [47:0] mdata(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Drive the memory for the current cycle, advance one clock, then score any fresh output
    task automatic tick();
        logic        p_rst, p_stall, p_branch;
        logic [31:0] e_pc;
        IMemRValid = 1'b0;
        IMemRData  = '0;
        IMemGnt    = gnt_en;
        if (RST) begin
            mq.delete();
            sb.delete();
        end else begin
            if (mq.size() > 0 && ncyc >= mq[0].t + lat) begin
                IMemRValid = 1'b1;
                IMemRData  = mdata(mq[0].a);
                nrv++;
                void'(mq.pop_front());
            end
            if (IMemReq && gnt_en) begin
                mq.push_back('{a: IMemAddr, t: ncyc});
                sb.push_back(IMemAddr);
                nacc++;
            end
            if (BranchTakenE) sb.delete();
        end
        p_rst    = RST;
        p_stall  = StallF;
        p_branch = BranchTakenE;
        @(posedge CLK);
        #1;
        ncyc++;
        if (!p_rst && !p_stall && !p_branch && ValidF) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got pc %0h want no instruction", PCF);
            end else begin
                e_pc = sb.pop_front();
                chk("sb_pc", 64'(PCF), 64'(e_pc));
                chk("sb_instr", 64'(InstrF), 64'(mdata(e_pc)));
            end
        end
    endtask

    task automatic do_reset();
        RST          = 1'b1;
        StallF       = 1'b0;
        BranchTakenE = 1'b0;
        PCTargetE    = '0;
        gnt_en       = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] want_pc);
        for (int k = 0; k < 20 && !ValidF; k++) tick();
        if (!ValidF) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got ValidF 0 want 1", name);
        end else begin
            chk(name, 64'(PCF), 64'(want_pc));
        end
    endtask

    initial begin
        vec_t vt[10];
        logic seen_req;
        vt[0] = '{1'b0, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
        vt[1] = '{1'b0, 1'b1, 1'b1, 32'd6,  1'b0, 32'd0};
        vt[2] = '{1'b0, 1'b1, 1'b1, 32'd12, 1'b1, 32'd0};
        vt[3] = '{1'b0, 1'b1, 1'b1, 32'd18, 1'b1, 32'd6};
        vt[4] = '{1'b0, 1'b1, 1'b1, 32'd24, 1'b1, 32'd12};
        vt[5] = '{1'b0, 1'b0, 1'b1, 32'd24, 1'b1, 32'd18};
        vt[6] = '{1'b0, 1'b0, 1'b1, 32'd24, 1'b0, 32'd0};
        vt[7] = '{1'b0, 1'b0, 1'b1, 32'd24, 1'b0, 32'd0};
        vt[8] = '{1'b0, 1'b1, 1'b1, 32'd30, 1'b0, 32'd0};
        vt[9] = '{1'b0, 1'b1, 1'b1, 32'd36, 1'b1, 32'd24};

        // Reset values, streaming, grant stall, wrap of the second instance
        do_reset();
        chk("rst_req", 64'(IMemReq), 64'h0);
        chk("rst_addr", 64'(IMemAddr), 64'h0);
        chk("rst_valid", 64'(ValidF), 64'h0);
        chk("rst_wrap_addr", 64'(w2_addr), 64'hFFFF_FFFC);
        for (int i = 0; i < 10; i++) begin
            StallF = vt[i].stall;
            gnt_en = vt[i].gnt;
            tick();
            chk("vec_req", 64'(IMemReq), 64'(vt[i].req));
            chk("vec_addr", 64'(IMemAddr), 64'(vt[i].addr));
            chk("vec_valid", 64'(ValidF), 64'(vt[i].valid));
            if (vt[i].valid) chk("vec_pc", 64'(PCF), 64'(vt[i].pc));
            else chk("vec_instr0", 64'(InstrF), 64'h0);
            if (i == 1) chk("wrap_addr", 64'(w2_addr), 64'h2);
        end

        // Reset after valid output, then stall from the start: two requests, then back-pressure
        do_reset();
        chk("rst2_valid", 64'(ValidF), 64'h0);
        chk("rst2_pc", 64'(PCF), 64'h0);
        chk("rst2_instr", 64'(InstrF), 64'h0);
        chk("rst2_addr", 64'(IMemAddr), 64'h0);
        StallF = 1'b1;
        nacc = 0;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_valid", 64'(ValidF), 64'h0);
        end
        chk("stall_nacc", 64'(nacc), 64'd2);
        chk("stall_req", 64'(IMemReq), 64'h0);
        StallF = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("release_valid", 64'(ValidF), 64'h1);
            chk("release_pc", 64'(PCF), 64'(k * 6));
        end
        StallF = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_pc", 64'(PCF), 64'd12);
            chk("hold_instr", 64'(InstrF), 64'(mdata(32'd12)));
        end
        StallF = 1'b0;
        tick();
        chk("hold_next_pc", 64'(PCF), 64'd18);

        // Redirect with two requests in flight
        do_reset();
        lat = 3;
        tick();
        tick();
        tick();
        chk("full_req", 64'(IMemReq), 64'h0);
        BranchTakenE = 1'b1;
        PCTargetE    = 32'h100;
        nrv          = 0;
        tick();
        BranchTakenE = 1'b0;
        chk("redir_addr", 64'(IMemAddr), 64'h100);
        chk("redir_valid", 64'(ValidF), 64'h0);
        chk("redir_instr", 64'(InstrF), 64'h0);
        chk("redir_req", 64'(IMemReq), 64'h0);
        seen_req = 1'b0;
        for (int k = 0; k < 20 && !seen_req; k++) begin
            tick();
            if (IMemReq) begin
                seen_req = 1'b1;
                chk("redir_drops", 64'(nrv), 64'd2);
                chk("redir_req_addr", 64'(IMemAddr), 64'h100);
            end
        end
        if (!seen_req) begin
            total++;
            bad++;
            $display("FAIL redir_req_timeout: got IMemReq 0 want 1");
        end
        wait_valid("redir_pc", 32'h100);

        // Redirect while stalled on a valid instruction with buffered entries
        do_reset();
        lat = 1;
        tick();
        tick();
        tick();
        chk("pre_valid", 64'(ValidF), 64'h1);
        StallF = 1'b1;
        tick();
        tick();
        tick();
        BranchTakenE = 1'b1;
        PCTargetE    = 32'h200;
        tick();
        BranchTakenE = 1'b0;
        chk("stredir_valid", 64'(ValidF), 64'h0);
        chk("stredir_instr", 64'(InstrF), 64'h0);
        chk("stredir_req", 64'(IMemReq), 64'h1);
        chk("stredir_addr", 64'(IMemAddr), 64'h200);
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt", 64'(StallCnt), 64'd4);
        chk("redir_cnt1", 64'(RedirCnt), 64'd1);
`endif
        StallF = 1'b0;
        wait_valid("stredir_pc", 32'h200);

        // Reload during redirect, then reset while one drop remains
        do_reset();
        lat = 3;
        tick();
        tick();
        tick();
        BranchTakenE = 1'b1;
        PCTargetE    = 32'h100;
        tick();
        PCTargetE = 32'h180;
        tick();
        BranchTakenE = 1'b0;
        chk("reload_addr", 64'(IMemAddr), 64'h180);
        chk("reload_req", 64'(IMemReq), 64'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("redir_cnt2", 64'(RedirCnt), 64'd2);
`endif
        RST = 1'b1;
        tick();
        chk("midrst_req", 64'(IMemReq), 64'h0);
        chk("midrst_addr", 64'(IMemAddr), 64'h0);
        chk("midrst_valid", 64'(ValidF), 64'h0);
        chk("midrst_instr", 64'(InstrF), 64'h0);
        chk("midrst_pc", 64'(PCF), 64'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("midrst_redir_cnt", 64'(RedirCnt), 64'h0);
        chk("midrst_stall_cnt", 64'(StallCnt), 64'h0);
`endif
        RST = 1'b0;
        lat = 1;
        tick();
        chk("idle_req", 64'(IMemReq), 64'h1);
        wait_valid("restart_pc", 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter SIZE, default 48, instruction width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter PC_INC, default 6, bytes per instruction.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-005 SHALL have one clock and a synchronous, active-high reset; all state changes on posedge CLK.
REQ-006 CLK  input  1  clock.
REQ-007 RST  input  1  reset; synchronous, active-high.
REQ-008 StallF  input  1  decode cannot accept; hold InstrF/PCF/ValidF.
REQ-009 BranchTakenE  input  1  redirect request.
REQ-010 PCTargetE  input  ADDR_W  redirect target, sampled when BranchTakenE=1.
REQ-011 IMemReq  output  1  fetch request valid.
REQ-012 IMemAddr  output  ADDR_W  fetch byte address.
REQ-013 IMemGnt  input  1  memory accepts request this cycle.
REQ-014 IMemRValid  input  1  read data valid, in request order.
REQ-015 IMemRData  input  SIZE  read data.
REQ-016 InstrF  output  SIZE  instruction to decode register.
REQ-017 PCF  output  ADDR_W  address of InstrF.
REQ-018 ValidF  output  1  InstrF holds a real instruction.

Function
REQ-019 Request handshake: a request is accepted when IMemReq=1 and IMemGnt=1; IMemAddr then advances by PC_INC the next cycle; IMemReq and IMemAddr stay stable until accepted.
REQ-020 At most 2 requests outstanding; IMemReq=0 when outstanding count plus buffered entries equals 2.
REQ-021 Responses are written into a 2-entry FIFO holding {data, PC}; the FIFO never overflows, as guaranteed by REQ-020.
REQ-022 Output register: when StallF=0, load the FIFO head into InstrF/PCF with ValidF=1 and pop it; if the FIFO is empty, load InstrF=0 and ValidF=0.
REQ-023 StallF=1 holds InstrF/PCF/ValidF unchanged; fetching continues until the REQ-020 limit is reached.
REQ-024 FSM states: IDLE (one cycle after reset, IMemReq=0) -> RUN -> REDIRECT -> RUN.
REQ-025 RUN + BranchTakenE: next cycle IMemAddr=PCTargetE, FIFO cleared, InstrF=0, ValidF=0 even if StallF=1, drop count = outstanding requests, state = REDIRECT.
REQ-026 REDIRECT: each IMemRValid decrements the drop count and its data is discarded; IMemReq is asserted at the target only once the drop count is 0; go to RUN on the first accepted request.
REQ-027 BranchTakenE during REDIRECT: reload the target; the drop count is unchanged.
REQ-028 A response arriving in the same cycle as BranchTakenE counts as outstanding and is discarded.
REQ-029 IMemAddr wraps modulo 2^ADDR_W.

Reset
REQ-030 With RST=1 at a posedge: state=IDLE, IMemAddr=RESET_PC, IMemReq=0, InstrF=0, PCF=0, ValidF=0, FIFO empty, outstanding=0, drop=0.
REQ-031 Reset mid-operation abandons in-flight requests; the memory side is reset together with this block.

Configuration
REQ-032 Macro FETCH_PERF_CNT_EN, when defined, adds 32-bit outputs StallCnt (cycles with StallF=1 and ValidF=1) and RedirCnt (accepted BranchTakenE events); both are 0 on reset and saturate at all-ones.
REQ-033 Without FETCH_PERF_CNT_EN, neither port nor counter exists and the remaining behaviour is identical.

Verification
REQ-034 Reset, then IMemGnt=1 and 1-cycle response latency -> IMemAddr 0, 6, 12...; ValidF rises; PCF 0, 6, 12 consecutively.
REQ-035 StallF=1 for 5 cycles with memory ready -> InstrF held, exactly 2 further requests issued, then IMemReq=0; release -> buffered PCs appear in order with no loss.
REQ-036 2 requests outstanding, BranchTakenE with PCTargetE=0x100 -> 2 responses dropped, next ValidF has PCF=0x100, InstrF=0 in the cycle after the redirect.
REQ-037 IMemGnt=0 for 3 cycles -> IMemReq and IMemAddr stable throughout.
REQ-038 RESET_PC=0xFFFFFFFC -> second IMemAddr = 0x00000002.
REQ-039 RST during REDIRECT with drop=1 -> all outputs match REQ-030 next cycle; with FETCH_PERF_CNT_EN, RedirCnt=0.
